// File: rtl/wb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// wb_bridge_pkg
// Shared types and constants for the Wishbone-to-counter bridge.
//   state_e    : bridge FSM state encoding (IDLE/REQ/ACK/ERR, 2 bits)
//   WB_SEL_W   : Wishbone byte-select width
//   WB_DAT_W   : Wishbone data/address width
//   tmo_cnt_w(): width of the REQ-cycle timeout counter
// Optional feature macro used by the bridge: WB_BRIDGE_TIMEOUT_EN
// ---------------------------------------------------------------------------
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam int WB_SEL_W = 4;
    localparam int WB_DAT_W = 32;

    // Counter only has to reach cycles-1, so $clog2(cycles) bits suffice.
    // Floor of 1 keeps the vector legal for the smallest allowed setting.
    function automatic int tmo_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/wb_bridge_timeout.sv
// ---------------------------------------------------------------------------
// wb_bridge_timeout
// Counts the cycles the bridge spends waiting in REQ and flags expiry on the
// last allowed cycle. Only instantiated when WB_BRIDGE_TIMEOUT_EN is defined.
// Ports:
//   clk     in  clock (posedge)
//   rst_n   in  asynchronous active-low reset
//   clr     in  hold counter at zero (bridge not in REQ)
//   en      in  count this cycle (bridge in REQ)
//   expire  out high in the REQ cycle where count == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module wb_bridge_timeout
    import wb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire = en && (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expire) begin
            // Saturate at the last value; the bridge leaves REQ on expiry anyway.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_counter_bridge.sv
// ---------------------------------------------------------------------------
// wb_counter_bridge
// Wishbone classic slave in front of the user-area counter. A bus cycle that
// hits the address window becomes one valid/wstrb/wdata request; the
// counter's ready pulse returns rdata to the bus with a one-cycle ack.
// Misses (and, optionally, stalled requests) end with a one-cycle err so the
// management SoC never hangs.
// Optional feature: define WB_BRIDGE_TIMEOUT_EN to terminate REQ with err
// after TIMEOUT_CYCLES cycles without ready.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   Wishbone slave inputs
//   wbs_ack_o, wbs_err_o         one-cycle termination pulses
//   wbs_dat_o                    read data, zero-extended from BITS
//   valid, wstrb, wdata          request to counter (wstrb 0 on reads)
//   ready, rdata                 counter response pulse and read data
//   busy_o                       high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module wb_counter_bridge
    import wb_bridge_pkg::*;
#(
    parameter int                   BITS           = 32,
    parameter logic [WB_DAT_W-1:0] ADDR_BASE      = 32'h3000_0000,
    parameter logic [WB_DAT_W-1:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int                   TIMEOUT_CYCLES = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [WB_SEL_W-1:0] wbs_sel_i,
    input  logic [WB_DAT_W-1:0] wbs_adr_i,
    input  logic [WB_DAT_W-1:0] wbs_dat_i,
    output logic                wbs_ack_o,
    output logic                wbs_err_o,
    output logic [WB_DAT_W-1:0] wbs_dat_o,
    output logic                valid,
    output logic [WB_SEL_W-1:0] wstrb,
    output logic [BITS-1:0]     wdata,
    input  logic                ready,
    input  logic [BITS-1:0]     rdata,
    output logic                busy_o
);

    state_e              state_q, state_d;
    logic [WB_SEL_W-1:0] wstrb_q, wstrb_d;
    logic [BITS-1:0]     wdata_q, wdata_d;
    logic [WB_DAT_W-1:0] dat_o_q, dat_o_d;

    logic addr_hit;
    logic tmo_expire;

    assign addr_hit = (wbs_adr_i & ADDR_MASK) == ADDR_BASE;

`ifdef WB_BRIDGE_TIMEOUT_EN
    wb_bridge_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clr    (state_q != ST_REQ),
        .en     (state_q == ST_REQ),
        .expire (tmo_expire)
    );
`else
    // No timeout: REQ waits for ready or abort. The expression is constant
    // false; it only keeps TIMEOUT_CYCLES referenced in this build.
    assign tmo_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        dat_o_d = dat_o_q;
        unique case (state_q)
            ST_IDLE: begin
                // ready is not looked at here, so stray pulses are dropped.
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (addr_hit) begin
                        wstrb_d = wbs_we_i ? wbs_sel_i : '0;
                        wdata_d = wbs_dat_i[BITS-1:0];
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                // Master abort outranks ready, which outranks the timeout.
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (ready) begin
                    dat_o_d             = '0;
                    dat_o_d[BITS-1:0]   = rdata;
                    state_d             = ST_ACK;
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            wstrb_q <= '0;
            wdata_q <= '0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            dat_o_q <= dat_o_d;
        end
    end

    // Handshake outputs are pure state decodes: valid drops the cycle after
    // ready (state has moved to ACK), and ack/err can never coincide.
    assign valid     = (state_q == ST_REQ);
    assign wbs_ack_o = (state_q == ST_ACK);
    assign wbs_err_o = (state_q == ST_ERR);
    assign busy_o    = (state_q != ST_IDLE);
    assign wstrb     = wstrb_q;
    assign wdata     = wdata_q;
    assign wbs_dat_o = dat_o_q;

endmodule

// File: tb/tb_wb_counter_bridge.sv
module tb_wb_counter_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic        ack, err, valid, busy, ready = 1'b0;
    logic [31:0] dat_o, wdata, rdata = 32'h0;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    wb_counter_bridge dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_err_o (err),
        .wbs_dat_o (dat_o),
        .valid     (valid),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .busy_o    (busy)
    );

    typedef struct {
        logic        is_err;
        logic [31:0] dat;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_dat = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // One bus cycle; the bench plays a 1-cycle registered counter that raises
    // ready in the second valid cycle. Called and returns on a negedge.
    task automatic wb_xfer(input string tag, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d, input logic [31:0] rd);
        exp_t e, got;
        int   n = 0;
        int   vcnt = 0;
        bit   done = 0;
        e.is_err = ((a & MASK) != BASE);
        e.wstrb  = w ? s : 4'h0;
        e.wdata  = d;
        e.dat    = e.is_err ? model_dat : rd;
        exp_q.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            ready = 1'b0;
            if (ack || err) begin
                got = exp_q.pop_front();
                chk({tag, "_err"},     {31'h0, err},   {31'h0, got.is_err});
                chk({tag, "_ack"},     {31'h0, ack},   {31'h0, !got.is_err});
                chk({tag, "_dat_o"},   dat_o,          got.dat);
                chk({tag, "_latency"}, n,              got.is_err ? 1 : 3);
                chk({tag, "_valid_n"}, vcnt,           got.is_err ? 0 : 2);
                chk({tag, "_valid_lo"}, {31'h0, valid}, 32'h0);
                model_dat = got.dat;
                cyc = 1'b0; stb = 1'b0;
                done = 1;
            end else if (valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    chk({tag, "_wstrb"}, {28'h0, wstrb}, {28'h0, e.wstrb});
                    chk({tag, "_wdata"}, wdata, e.wdata);
                end
                if (vcnt == 2) begin
                    ready = 1'b1;
                    rdata = rd;
                end
            end
        end
        if (!done) begin
            chk({tag, "_no_response"}, 32'h0, 32'h1);
            cyc = 1'b0; stb = 1'b0;
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        chk({tag, "_after"}, {29'h0, ack, err, busy}, 32'h0);
        $display("txn %s we=%0b adr=%08h sel=%b dat=%08h -> dat_o=%08h err=%0b",
                 tag, w, a, s, d, dat_o, e.is_err);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {28'h0, ack, err, valid, busy}, 32'h0);
        chk("rst_wstrb", {28'h0, wstrb}, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_dat_o", dat_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1-3: write, read, miss, window edges
        wb_xfer("t1_write", 1'b1, 32'h3000_0000, 4'b1111, 32'h1234_5678, 32'h0000_0000);
        wb_xfer("t2_read",  1'b0, 32'h3000_0004, 4'b1111, 32'hDEAD_0000, 32'h0000_00AA);
        wb_xfer("t3_miss",  1'b0, 32'h2000_0000, 4'b1111, 32'h0,         32'h0000_0055);
        wb_xfer("t3_top",   1'b1, 32'h3000_FFFC, 4'b0101, 32'hCAFE_BABE, 32'h0000_0077);
        wb_xfer("t3_above", 1'b1, 32'h3001_0000, 4'b0011, 32'h1111_2222, 32'h0000_0099);

        // 4: master abort while ready is held low, then a late ready
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0010; sel = 4'b1100; dat = 32'hA5A5_5A5A;
        @(negedge clk);
        chk("t4_valid1", {31'h0, valid}, 32'h1);
        @(negedge clk);
        chk("t4_valid2", {31'h0, valid}, 32'h1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("t4_abort", {28'h0, ack, err, valid, busy}, 32'h0);
        ready = 1'b1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        ready = 1'b0;
        chk("t4_late_ready", {28'h0, ack, err, valid, busy}, 32'h0);
        chk("t4_dat_o", dat_o, model_dat);
        $display("txn t4_abort adr=30000010 -> no termination");

        // 5: ready never arrives
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0020; sel = 4'b1111;
        begin
            int n = 0;
            int vcnt = 0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            while (!err && n < 40) begin
                @(negedge clk);
                n++;
                if (valid) vcnt++;
                chk("t5_no_ack", {31'h0, ack}, 32'h0);
            end
            chk("t5_err_cycle", n, 17);
            chk("t5_req_cycles", vcnt, 16);
            chk("t5_dat_o", dat_o, model_dat);
            cyc = 1'b0; stb = 1'b0;
`else
            repeat (40) begin
                @(negedge clk);
                n++;
                if (valid) vcnt++;
                chk("t5_stall", {29'h0, busy, ack, err}, 32'h4);
            end
            chk("t5_req_cycles", vcnt, n);
            cyc = 1'b0; stb = 1'b0;
`endif
        end
        @(negedge clk);
        chk("t5_idle", {28'h0, ack, err, valid, busy}, 32'h0);
        $display("txn t5_stall adr=30000020 -> terminated");

        // 6: asynchronous reset in the middle of REQ
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0030; sel = 4'b1111; dat = 32'h0BAD_F00D;
        @(negedge clk);
        chk("t6_valid", {31'h0, valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_ctrl", {28'h0, ack, err, valid, busy}, 32'h0);
        chk("t6_async_wstrb", {28'h0, wstrb}, 32'h0);
        chk("t6_async_wdata", wdata, 32'h0);
        chk("t6_async_dat_o", dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        model_dat = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_held_ctrl", {28'h0, ack, err, valid, busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn t6_reset adr=30000030 -> reset mid-request");
        wb_xfer("t6_after", 1'b1, 32'h3000_0040, 4'b1001, 32'h8765_4321, 32'h0000_0123);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
